// File: rtl/cpu_bus_interface_if.sv
// Memory-bus bundle between cpu_control/datapath and the bus sequencer.
// Handshake: the sequencer holds bus_read or bus_write high from T1 through
// the last T2 clock. The memory side raises bus_ready in the clock in which
// the access may complete. bus_ready is sampled only in T2 of an active
// access and is ignored in every other clock.
interface cpu_bus_interface_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [1:0]        t_cycle;
   logic              mem_enable;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_data_in;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_read;
   logic              bus_write;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ready;
   logic              bus_error;

   // Control unit, datapath and memory side
   modport master (
      input  t_cycle, mem_data_in, bus_addr, bus_wdata, bus_read, bus_write, bus_error,
      output mem_enable, mem_write, mem_addr, mem_wdata, bus_rdata, bus_ready
   );

   // Bus sequencer side
   modport slave (
      output t_cycle, mem_data_in, bus_addr, bus_wdata, bus_read, bus_write, bus_error,
      input  mem_enable, mem_write, mem_addr, mem_wdata, bus_rdata, bus_ready
   );
endinterface

// File: rtl/cpu_bus_interface.sv
// Memory-bus sequencer. It produces the T-cycle count, latches the access
// request at the end of T0, drives registered strobes from T1 through T2,
// stretches T2 with wait states until bus_ready, and returns read data from T3.
// A wait-state timeout completes the access with OPEN_BUS data and a
// one-clock bus_error pulse.
module cpu_bus_interface #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter int                MAX_WAIT = 15,
   parameter logic [DATA_W-1:0] OPEN_BUS = 8'hFF
) (
   input logic                clk,
   input logic                reset_n,
   cpu_bus_interface_if.slave bus
);

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam int             WCW      = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

   logic [1:0]        t_q;
   logic              active_q;
   logic              write_q;
   logic [WCW-1:0]    wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              read_stb;
   logic              write_stb;
   logic              error_q;

   logic t2_active;
   logic stall;
   logic finish;

   // T2 of a real access either waits for bus_ready or ends on timeout
   always_comb begin
      t2_active = (t_q == T2) && active_q;
      stall     = t2_active && !bus.bus_ready && (wait_cnt != WAIT_LIM);
      finish    = t2_active && !stall;
   end

   // T-cycle counter; holds at T2 while stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         t_q <= T0;
      else if (!stall)
         t_q <= t_q + 2'd1;
   end

   // Request capture at the end of T0; bus address/data only move for real accesses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else if (t_q == T0) begin
         active_q <= bus.mem_enable;
         write_q  <= bus.mem_write;
         if (bus.mem_enable) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
         end
      end
   end

   // Strobes rise with the capture and drop on the edge that leaves T2
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_stb  <= 1'b0;
         write_stb <= 1'b0;
      end else if (t_q == T0) begin
         read_stb  <= bus.mem_enable && !bus.mem_write;
         write_stb <= bus.mem_enable && bus.mem_write;
      end else if (t_q == T2 && !stall) begin
         read_stb  <= 1'b0;
         write_stb <= 1'b0;
      end
   end

   // Wait-state counter counts stalled T2 clocks and clears when T2 ends
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         wait_cnt <= '0;
      else if (stall)
         wait_cnt <= wait_cnt + WCW'(1);
      else if (t_q == T2)
         wait_cnt <= '0;
   end

   // Completion: read data capture and the one-clock timeout pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         error_q <= finish && !bus.bus_ready;
         if (finish && !write_q)
            rdata_q <= bus.bus_ready ? bus.bus_rdata : OPEN_BUS;
      end
   end

   assign bus.t_cycle     = t_q;
   assign bus.bus_addr    = addr_q;
   assign bus.bus_wdata   = wdata_q;
   assign bus.bus_read    = read_stb;
   assign bus.bus_write   = write_stb;
   assign bus.bus_error   = error_q;
   assign bus.mem_data_in = rdata_q;

endmodule
